// File: rtl/key_sched_ctrl_pkg.sv
// Shared constants for the AES-128 key-schedule controller: sizes, FSM encoding,
// round-constant table and S-box lookup used by the single-round expansion block.
package key_sched_ctrl_pkg;

    localparam int NR = 32'd10;
    localparam int KW = 32'd128;
    localparam logic [3:0] LAST_RC = 4'd9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        FINISH = 2'd2
    } state_e;

    // Byte 0x00 maps to the most significant byte of the table.
    localparam logic [2047:0] SBOX_TABLE = {
        256'h637c777bf26b6fc53001672bfed7ab76ca82c97dfa5947f0add4a2af9ca472c0,
        256'hb7fd9326363ff7cc34a5e5f171d8311504c723c31896059a071280e2eb27b275,
        256'h09832c1a1b6e5aa0523bd6b329e32f8453d100ed20fcb15b6acbbe394a4c58cf,
        256'hd0efaafb434d338545f9027f503c9fa851a3408f929d38f5bcb6da2110fff3d2,
        256'hcd0c13ec5f974417c4a77e3d645d197360814fdc222a908846eeb814de5e0bdb,
        256'he0323a0a4906245cc2d3ac629195e479e7c8376d8dd54ea96c56f4ea657aae08,
        256'hba78252e1ca6b4c6e8dd741f4bbd8b8a703eb5664803f60e613557b986c11d9e,
        256'he1f8981169d98e949b1e87e9ce5528df8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] idx;
        idx = {~b, 3'b000};
        return SBOX_TABLE[idx +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] r;
        case (idx)
            4'd0:    r = 8'h01;
            4'd1:    r = 8'h02;
            4'd2:    r = 8'h04;
            4'd3:    r = 8'h08;
            4'd4:    r = 8'h10;
            4'd5:    r = 8'h20;
            4'd6:    r = 8'h40;
            4'd7:    r = 8'h80;
            4'd8:    r = 8'h1b;
            4'd9:    r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/key_sched_ctrl_round.sv
// Single-round AES-128 key expansion: derives round key rnd+1 from round key rnd.
module key_sched_ctrl_round
    import key_sched_ctrl_pkg::*;
(
    input  logic [3:0]    rnd,
    input  logic [KW-1:0] key_i,
    output logic [KW-1:0] key_o
);

    logic [31:0] w0_s, w1_s, w2_s, w3_s;
    logic [31:0] rot_s, sub_s, tmp_s;
    logic [31:0] n0_s, n1_s, n2_s, n3_s;

    // RotWord, SubWord and round constant on the last word, then the xor chain.
    always_comb begin
        w0_s  = key_i[127:96];
        w1_s  = key_i[95:64];
        w2_s  = key_i[63:32];
        w3_s  = key_i[31:0];
        rot_s = {w3_s[23:0], w3_s[31:24]};
        sub_s = {sbox(rot_s[31:24]), sbox(rot_s[23:16]), sbox(rot_s[15:8]), sbox(rot_s[7:0])};
        tmp_s = sub_s ^ {rcon(rnd), 24'h000000};
        n0_s  = w0_s ^ tmp_s;
        n1_s  = w1_s ^ n0_s;
        n2_s  = w2_s ^ n1_s;
        n3_s  = w3_s ^ n2_s;
        key_o = {n0_s, n1_s, n2_s, n3_s};
    end

endmodule

// File: rtl/key_sched_ctrl.sv
// Sequential AES-128 key-schedule controller: one shared expansion round iterated
// ten times, round keys 0..10 held in a bank behind a combinational read port.
module key_sched_ctrl
    import key_sched_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [KW-1:0] key_in,
    output logic          busy,
    output logic          done,
    output logic          keys_valid,
    input  logic [3:0]    rk_addr,
    output logic [KW-1:0] rk_data
);

    state_e        state_q, state_d;
    logic [3:0]    rc_q, rc_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          kv_q, kv_d;
    logic [KW-1:0] bank_q [NR+1];

    logic          bank_we_s;
    logic [3:0]    bank_waddr_s;
    logic [KW-1:0] bank_wdata_s;
    logic [KW-1:0] round_out_s;

    key_sched_ctrl_round u_round (
        .rnd   (rc_q),
        .key_i (bank_q[rc_q]),
        .key_o (round_out_s)
    );

    // Next-state, counter, status flags and the single bank write port.
    always_comb begin
        state_d      = state_q;
        rc_d         = rc_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        kv_d         = kv_q;
        bank_we_s    = 1'b0;
        bank_waddr_s = 4'd0;
        bank_wdata_s = '0;
        case (state_q)
            IDLE, FINISH: begin
                if (start) begin
                    state_d      = EXPAND;
                    rc_d         = 4'd0;
                    busy_d       = 1'b1;
                    kv_d         = 1'b0;
                    bank_we_s    = 1'b1;
                    bank_waddr_s = 4'd0;
                    bank_wdata_s = key_in;
                end else begin
                    state_d = IDLE;
                end
            end
            EXPAND: begin
                bank_we_s    = 1'b1;
                bank_waddr_s = rc_q + 4'd1;
                bank_wdata_s = round_out_s;
                rc_d         = rc_q + 4'd1;
                if (rc_q == LAST_RC) begin
                    state_d = FINISH;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    kv_d    = 1'b1;
                end else begin
                    state_d = EXPAND;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                kv_d    = 1'b0;
            end
        endcase
    end

    // Control and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rc_q    <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            kv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rc_q    <= rc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            kv_q    <= kv_d;
        end
    end

    // Round-key bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NR + 1; i++) begin
                bank_q[i] <= '0;
            end
        end else if (bank_we_s) begin
            bank_q[bank_waddr_s] <= bank_wdata_s;
        end else begin
            bank_q <= bank_q;
        end
    end

    // Indexed read; addresses past the last round key read as zero.
    always_comb begin
        if (rk_addr <= 4'(NR)) begin
            rk_data = bank_q[rk_addr];
        end else begin
            rk_data = '0;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign keys_valid = kv_q;

endmodule

// File: tb/tb_key_sched_ctrl.sv
// Scenario bench for key_sched_ctrl with a queue of expected round keys per run.
module tb_key_sched_ctrl;

    localparam logic [127:0] KEY_A   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] RK_A1   = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] RK_A10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KEY_B   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] RK_B10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] RK_Z1   = 128'h62636363626363636263636362636363;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [127:0] key_in = '0;
    logic         busy, done, keys_valid;
    logic [3:0]   rk_addr = 4'd0;
    logic [127:0] rk_data;

    typedef struct {
        logic [3:0]   addr;
        logic [127:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    key_sched_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .key_in     (key_in),
        .busy       (busy),
        .done       (done),
        .keys_valid (keys_valid),
        .rk_addr    (rk_addr),
        .rk_data    (rk_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [3:0] a, input logic [127:0] d);
        exp_t e;
        e.addr = a;
        e.data = d;
        sb_q.push_back(e);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({busy, done, keys_valid} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_flags: got busy/done/kv=%b required 000", {busy, done, keys_valid});
        end
        for (int a = 0; a <= 10; a++) begin
            rk_addr = 4'(a);
            #1;
            n_cmp++;
            if (rk_data !== 128'd0) begin
                n_err++;
                $display("FAIL reset_bank[%0d]: got %h required 0", a, rk_data);
            end
        end
    endtask

    task automatic test_fips_and_busy();
        int first_done;
        int pulses;
        exp_t e;
        push_exp(4'd1, RK_A1);
        push_exp(4'd10, RK_A10);
        push_exp(4'd0, KEY_A);
        key_in = KEY_A;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        key_in = '0;
        first_done = -1;
        pulses = 0;
        for (int k = 1; k <= 20; k++) begin
            if (k == 4) start = 1'b1;
            tick();
            start = 1'b0;
            if (k == 1) begin
                n_cmp++;
                if (busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL fips_busy: got %b required 1", busy);
                end
            end
            if (done === 1'b1) begin
                pulses++;
                if (first_done < 0) first_done = k;
            end
        end
        n_cmp++;
        if (first_done != 10) begin
            n_err++;
            $display("FAIL fips_done_latency: got %0d edges required 10", first_done);
        end
        n_cmp++;
        if (pulses != 1) begin
            n_err++;
            $display("FAIL busy_start_pulses: got %0d required 1", pulses);
        end
        n_cmp++;
        if ({busy, keys_valid} !== 2'b01) begin
            n_err++;
            $display("FAIL fips_flags: got busy/kv=%b required 01", {busy, keys_valid});
        end
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            rk_addr = e.addr;
            #1;
            n_cmp++;
            if (rk_data !== e.data) begin
                n_err++;
                $display("FAIL fips_rk[%0d]: got %h required %h", e.addr, rk_data, e.data);
            end
        end
    endtask

    task automatic test_out_of_range();
        logic [3:0] addrs [2];
        addrs[0] = 4'd11;
        addrs[1] = 4'd15;
        for (int i = 0; i < 2; i++) begin
            rk_addr = addrs[i];
            #1;
            n_cmp++;
            if (rk_data !== 128'd0 || keys_valid !== 1'b1) begin
                n_err++;
                $display("FAIL oor_read[%0d]: got data=%h kv=%b required 0 kv=1", addrs[i], rk_data, keys_valid);
            end
        end
    endtask

    task automatic test_reexpand_zero();
        int lows;
        int seen_high;
        exp_t e;
        push_exp(4'd1, RK_Z1);
        push_exp(4'd0, 128'd0);
        key_in = '0;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        lows = 0;
        seen_high = 0;
        for (int k = 0; k < 15 && seen_high == 0; k++) begin
            if (keys_valid === 1'b0) lows++;
            else seen_high = 1;
            if (seen_high == 0) tick();
        end
        n_cmp++;
        if (lows != 10 || seen_high != 1) begin
            n_err++;
            $display("FAIL reexp_kv_low: got %0d low cycles (high seen %0d) required 10", lows, seen_high);
        end
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            rk_addr = e.addr;
            #1;
            n_cmp++;
            if (rk_data !== e.data) begin
                n_err++;
                $display("FAIL reexp_rk[%0d]: got %h required %h", e.addr, rk_data, e.data);
            end
        end
    endtask

    task automatic test_back_to_back();
        int got;
        exp_t e;
        key_in = KEY_A;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        got = 0;
        for (int k = 0; k < 20 && got == 0; k++) begin
            tick();
            if (done === 1'b1) got = 1;
        end
        n_cmp++;
        if (got != 1) begin
            n_err++;
            $display("FAIL b2b_first_done: got timeout required done");
        end
        push_exp(4'd10, RK_B10);
        push_exp(4'd0, KEY_B);
        key_in = KEY_B;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        n_cmp++;
        if ({busy, done, keys_valid} !== 3'b100) begin
            n_err++;
            $display("FAIL b2b_accept: got busy/done/kv=%b required 100", {busy, done, keys_valid});
        end
        got = 0;
        for (int k = 1; k <= 20 && got == 0; k++) begin
            tick();
            if (done === 1'b1) got = k;
        end
        n_cmp++;
        if (got != 10) begin
            n_err++;
            $display("FAIL b2b_done_latency: got %0d edges required 10", got);
        end
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            rk_addr = e.addr;
            #1;
            n_cmp++;
            if (rk_data !== e.data) begin
                n_err++;
                $display("FAIL b2b_rk[%0d]: got %h required %h", e.addr, rk_data, e.data);
            end
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        key_in = KEY_A;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        for (int k = 1; k <= 5; k++) tick();
        rst    = 1'b1;
        start  = 1'b1;
        key_in = KEY_B;
        tick();
        rst    = 1'b0;
        start  = 1'b0;
        n_cmp++;
        if ({busy, done, keys_valid} !== 3'b000) begin
            n_err++;
            $display("FAIL rstmid_flags: got busy/done/kv=%b required 000", {busy, done, keys_valid});
        end
        pulses = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses != 0 || keys_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_quiet: got %0d active cycles kv=%b required 0 kv=0", pulses, keys_valid);
        end
        for (int a = 0; a <= 10; a++) begin
            rk_addr = 4'(a);
            #1;
            n_cmp++;
            if (rk_data !== 128'd0) begin
                n_err++;
                $display("FAIL rstmid_bank[%0d]: got %h required 0", a, rk_data);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fips_and_busy();
        test_out_of_range();
        test_reexpand_zero();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
